// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the DDS frequency-sweep controller.
// Contents:
//   PHASE_W_DEF / DWELL_W_DEF : default accumulator and dwell-counter widths
//   STYLE_W / OFFSET_W        : waveform-select and phase-offset widths
//   BURST_W                   : burst-count width (DDS_SWEEP_BURST_EN builds)
//   sweep_state_e             : controller FSM states IDLE / ARMED / SWEEP
package dds_pkg;

  localparam int PHASE_W_DEF = 28;
  localparam int DWELL_W_DEF = 16;
  localparam int STYLE_W     = 2;
  localparam int OFFSET_W    = 14;
  localparam int BURST_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SWEEP = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/phase_accum.sv
// phase_accum: DDS phase accumulator, wraps modulo 2^PHASE_W.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset (clears phase)
//   i_en         add i_inc to the phase this cycle
//   i_load_zero  force phase to zero (has priority over i_en)
//   i_inc        phase increment
//   o_phase      accumulated phase (registered)
module phase_accum
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_load_zero,
  input  logic [PHASE_W-1:0] i_inc,
  output logic [PHASE_W-1:0] o_phase
);

  logic [PHASE_W-1:0] r_phase;

  // Phase register: clear, zero-load or accumulate (carry out is discarded)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= '0;
    end else if (i_load_zero) begin
      r_phase <= '0;
    end else if (i_en) begin
      r_phase <= r_phase + i_inc;
    end else begin
      r_phase <= r_phase;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: stepped frequency-sweep controller driving a DDS waveform
// generator. A configuration is accepted in IDLE/ARMED, start launches the
// sweep, and the increment steps from start_inc toward stop_inc, each value
// held for dwell+1 cycles. Completion pulses o_done and returns to ARMED.
// Optional feature macro: DDS_SWEEP_BURST_EN adds i_cfg_bursts and repeats
// the sweep that many times (0 treated as 1) with continuous phase.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cfg_valid / o_cfg_ready    configuration handshake
//   i_cfg_start_inc/stop_inc/step/dwell, i_cfg_style, i_cfg_offset
//   i_cfg_bursts                 (DDS_SWEEP_BURST_EN only)
//   i_start, i_abort             sweep control
//   o_phase, o_wave_style, o_phase_offset   waveform generator drive
//   o_cur_inc, o_busy, o_armed, o_done      status
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [PHASE_W-1:0]  i_cfg_start_inc,
  input  logic [PHASE_W-1:0]  i_cfg_stop_inc,
  input  logic [PHASE_W-1:0]  i_cfg_step,
  input  logic [DWELL_W-1:0]  i_cfg_dwell,
  input  logic [STYLE_W-1:0]  i_cfg_style,
  input  logic [OFFSET_W-1:0] i_cfg_offset,
`ifdef DDS_SWEEP_BURST_EN
  input  logic [BURST_W-1:0]  i_cfg_bursts,
`endif
  input  logic                i_start,
  input  logic                i_abort,
  output logic [PHASE_W-1:0]  o_phase,
  output logic [STYLE_W-1:0]  o_wave_style,
  output logic [OFFSET_W-1:0] o_phase_offset,
  output logic [PHASE_W-1:0]  o_cur_inc,
  output logic                o_busy,
  output logic                o_armed,
  output logic                o_done
);

  // Increment step that saturates at the limit; the sum is one bit wider so
  // a carry out of PHASE_W bits still clamps to the limit.
  function automatic logic [PHASE_W-1:0] sat_add(
    input logic [PHASE_W-1:0] a,
    input logic [PHASE_W-1:0] b,
    input logic [PHASE_W-1:0] lim
  );
    logic [PHASE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) begin
      sat_add = lim;
    end else begin
      sat_add = sum[PHASE_W-1:0];
    end
  endfunction

  sweep_state_e        r_state;
  sweep_state_e        w_state_nxt;

  logic [PHASE_W-1:0]  r_start_inc;
  logic [PHASE_W-1:0]  r_stop_inc;
  logic [PHASE_W-1:0]  r_step;
  logic [DWELL_W-1:0]  r_dwell;
  logic [STYLE_W-1:0]  r_style;
  logic [OFFSET_W-1:0] r_offset;
  logic [PHASE_W-1:0]  r_cur_inc;
  logic [DWELL_W-1:0]  r_dwell_cnt;
  logic                r_done;
  logic                r_busy;
  logic                r_armed;
  logic                r_cfg_ready;

  logic                w_accept;
  logic                w_go;
  logic                w_count;
  logic                w_step_up;
  logic                w_reload;
  logic                w_complete;
  logic                w_last_burst;
  logic                w_phase_en;
  logic [PHASE_W-1:0]  w_phase;

`ifdef DDS_SWEEP_BURST_EN
  logic [BURST_W-1:0]  r_bursts;
  logic [BURST_W-1:0]  r_burst_idx;
  logic [BURST_W-1:0]  w_bursts_eff;

  // A burst count of zero behaves as a single burst
  assign w_bursts_eff = (r_bursts == 16'd0) ? 16'd1 : r_bursts;
  assign w_last_burst = ((r_burst_idx + 16'd1) >= w_bursts_eff);

  // Burst configuration and index of the burst in progress
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bursts    <= 16'd0;
      r_burst_idx <= 16'd0;
    end else begin
      if (w_accept) begin
        r_bursts <= i_cfg_bursts;
      end else begin
        r_bursts <= r_bursts;
      end
      if (w_go) begin
        r_burst_idx <= 16'd0;
      end else if (w_reload) begin
        r_burst_idx <= r_burst_idx + 16'd1;
      end else begin
        r_burst_idx <= r_burst_idx;
      end
    end
  end
`else
  assign w_last_burst = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and datapath strobes; cfg beats start, abort beats expiry
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_go        = 1'b0;
    w_count     = 1'b0;
    w_step_up   = 1'b0;
    w_reload    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cfg_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ARMED;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ARMED: begin
        if (i_cfg_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ARMED;
        end else if (i_start) begin
          w_go        = 1'b1;
          w_state_nxt = SWEEP;
        end else begin
          w_state_nxt = ARMED;
        end
      end
      SWEEP: begin
        if (i_abort) begin
          w_state_nxt = ARMED;
        end else if (r_dwell_cnt != r_dwell) begin
          w_count     = 1'b1;
          w_state_nxt = SWEEP;
        end else if (r_cur_inc < r_stop_inc) begin
          w_step_up   = 1'b1;
          w_state_nxt = SWEEP;
        end else if (!w_last_burst) begin
          w_reload    = 1'b1;
          w_state_nxt = SWEEP;
        end else begin
          w_complete  = 1'b1;
          w_state_nxt = ARMED;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Phase advances every sweep cycle, including the completing one; an
  // abort freezes it on the same edge.
  assign w_phase_en = (r_state == SWEEP) && !i_abort;

  // Configuration latch, increment/dwell datapath and registered status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_start_inc <= '0;
      r_stop_inc  <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_style     <= '0;
      r_offset    <= '0;
      r_cur_inc   <= '0;
      r_dwell_cnt <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_armed     <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_done      <= w_complete;
      r_busy      <= (w_state_nxt == SWEEP);
      r_armed     <= (w_state_nxt == ARMED);
      r_cfg_ready <= (w_state_nxt != SWEEP);
      if (w_accept) begin
        r_start_inc <= i_cfg_start_inc;
        r_stop_inc  <= i_cfg_stop_inc;
        r_step      <= i_cfg_step;
        r_dwell     <= i_cfg_dwell;
        r_style     <= i_cfg_style;
        r_offset    <= i_cfg_offset;
      end else begin
        r_start_inc <= r_start_inc;
        r_stop_inc  <= r_stop_inc;
        r_step      <= r_step;
        r_dwell     <= r_dwell;
        r_style     <= r_style;
        r_offset    <= r_offset;
      end
      if (w_go || w_reload) begin
        r_cur_inc   <= r_start_inc;
        r_dwell_cnt <= '0;
      end else if (w_step_up) begin
        r_cur_inc   <= sat_add(r_cur_inc, r_step, r_stop_inc);
        r_dwell_cnt <= '0;
      end else if (w_count) begin
        r_cur_inc   <= r_cur_inc;
        r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
      end else begin
        r_cur_inc   <= r_cur_inc;
        r_dwell_cnt <= r_dwell_cnt;
      end
    end
  end

  phase_accum #(
    .PHASE_W (PHASE_W)
  ) u_phase_accum (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_phase_en),
    .i_load_zero (w_go),
    .i_inc       (r_cur_inc),
    .o_phase     (w_phase)
  );

  assign o_phase        = w_phase;
  assign o_wave_style   = r_style;
  assign o_phase_offset = r_offset;
  assign o_cur_inc      = r_cur_inc;
  assign o_busy         = r_busy;
  assign o_armed        = r_armed;
  assign o_done         = r_done;
  assign o_cfg_ready    = r_cfg_ready;

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL provide parameter PHASE_W, default 28: phase accumulator and increment width.
REQ-002 SHALL provide parameter DWELL_W, default 16: dwell counter width.
REQ-003 SHALL use a single clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL provide the configuration handshake ports: cfg_valid input 1; cfg_ready output 1.
REQ-005 SHALL provide the sweep configuration inputs: cfg_start_inc input PHASE_W; cfg_stop_inc input PHASE_W; cfg_step input PHASE_W; cfg_dwell input DWELL_W.
REQ-006 SHALL provide the waveform configuration inputs: cfg_style input 2 (waveform select); cfg_offset input 14 (phase offset).
REQ-007 SHALL provide the control inputs: start input 1 (begin armed sweep); abort input 1 (stop sweep).
REQ-008 SHALL provide the waveform-generator drive outputs: phase output PHASE_W; wave_style output 2; phase_offset output 14.
REQ-009 SHALL provide the status outputs: cur_inc output PHASE_W; busy output 1 (state == SWEEP); armed output 1; done output 1 (single-cycle completion pulse).

Function
REQ-010 SHALL implement an FSM with states IDLE, ARMED and SWEEP.
REQ-011 SHALL drive cfg_ready = 1 in IDLE and ARMED, and 0 in SWEEP.
REQ-012 SHALL latch all cfg_* inputs when cfg_valid && cfg_ready, entering ARMED the next cycle.
REQ-013 SHALL update wave_style and phase_offset from the latched values on the cycle after acceptance.
REQ-014 SHALL ignore start unless the state is ARMED.
REQ-015 SHALL give cfg acceptance priority when cfg_valid and start coincide in ARMED: start is dropped and the FSM stays ARMED.
REQ-016 On start in ARMED at edge k: SHALL enter SWEEP, load cur_inc = start_inc, clear the dwell counter, and hold phase = 0 at k+1.
REQ-017 In SWEEP: SHALL update phase <= phase + cur_inc each cycle, modulo 2^PHASE_W, wrapping silently; first nonzero phase is at k+2.
REQ-018 SHALL hold each cur_inc value for dwell+1 cycles; dwell = 0 updates every cycle.
REQ-019 On dwell expiry with cur_inc < stop_inc: SHALL set cur_inc <= min(cur_inc + step, stop_inc), computing the sum at PHASE_W+1 bits so a carry saturates to stop_inc.
REQ-020 On dwell expiry with cur_inc >= stop_inc: SHALL complete the sweep (see REQ-033/034).
REQ-021 If step == 0 and start_inc < stop_inc: SHALL hold a fixed tone, with SWEEP left only by abort or reset.
REQ-022 If start_inc >= stop_inc: SHALL run one dwell period at start_inc, then complete.
REQ-023 On sweep completion: SHALL pulse done high for exactly 1 cycle, return to ARMED with configuration retained, and freeze phase and cur_inc.
REQ-024 On abort in SWEEP: SHALL go to ARMED next cycle, freeze phase, and raise no done.
REQ-025 SHALL give abort priority over a coincident dwell expiry or completion.
REQ-026 SHALL ignore abort outside SWEEP.
REQ-027 SHALL assert busy only in SWEEP and armed only in ARMED.

Reset
REQ-028 rst SHALL dominate all other inputs in the same cycle.
REQ-029 On rst: SHALL enter IDLE and clear phase, cur_inc, wave_style, phase_offset, the dwell counter, done, busy and armed to 0; cfg_ready SHALL be 1 after reset.
REQ-030 rst asserted mid-SWEEP SHALL abandon the sweep with no done pulse; the latched configuration SHALL be cleared.

Configuration
REQ-031 Burst repetition SHALL be compiled in by macro DDS_SWEEP_BURST_EN.
REQ-032 With DDS_SWEEP_BURST_EN defined: SHALL add input cfg_bursts, width 16, latched with the other cfg_* inputs.
REQ-033 With DDS_SWEEP_BURST_EN defined: SHALL repeat the sweep cfg_bursts times, treating 0 as 1. Between bursts, cur_inc SHALL reload to start_inc while phase continues uninterrupted. done SHALL pulse only after the final burst.
REQ-034 Without DDS_SWEEP_BURST_EN: SHALL omit the cfg_bursts port and complete after a single sweep.

Structure
REQ-035 SHALL place the FSM state enum (IDLE/ARMED/SWEEP) and the default widths in shared package dds_pkg.
REQ-036 SHALL implement the phase accumulator as sub-module phase_accum (enable, load-zero, increment input, PHASE_W output), instantiated once.
REQ-037 SHALL connect phase[27:0], phase_offset and wave_style directly to the existing waveform generator inputs with no added latency.

Verification
REQ-038 Scenario: cfg start=100, stop=400, step=100, dwell=1, then start -> cur_inc sequence 100,100,200,200,300,300,400,400; done at the cycle after the final 400; phase=0,100,200,400,600,900,1200,1600,2000.
REQ-039 Scenario: cfg start=0x0FFFFFF0, stop=0x0FFFFFFF, step=0x20, dwell=0 -> cur_inc saturates to 0x0FFFFFFF in one step; phase wraps modulo 2^28 with no flag.
REQ-040 Scenario: abort on the same edge as the final dwell expiry -> state ARMED, no done pulse, phase frozen.
REQ-041 Scenario: cfg_valid and start both high in ARMED -> new configuration latched, busy stays 0; a subsequent start runs the new values.
REQ-042 Scenario: rst asserted 3 cycles into SWEEP -> next cycle all outputs 0, cfg_ready=1, armed=0.
REQ-043 Scenario: DDS_SWEEP_BURST_EN with cfg_bursts=3, start=10, stop=30, step=10, dwell=0 -> cur_inc 10,20,30 repeated 3 times, phase continuous across bursts, exactly one done pulse.
